// File: rtl/uart_tx_sequencer_pkg.sv
// uart_tx_sequencer_pkg: shared widths, UART register map, sequencer states and CTRL layout
package uart_tx_sequencer_pkg;
  localparam int DATA_W = 32;
  localparam int TX_FULL_BIT = 31;
  localparam int CTRL_TX_START = 0;
  localparam int CTRL_STOP2 = 1;
  typedef enum logic [DATA_W-1:0] {
    UART_BAUD_REG    = 32'h0000_0004,
    UART_CTRL_REG    = 32'h0000_0008,
    UART_TX_DATA_REG = 32'h0000_000C
  } uart_registers_e;
  typedef enum logic [2:0] {WAIT, CFG_BAUD, CFG_CTRL, IDLE, POLL, WRITE} seq_state_e;
  function automatic logic [DATA_W-1:0] ctrl_word(input logic two_stop);
    ctrl_word = '0;
    ctrl_word[CTRL_TX_START] = 1'b1;
    ctrl_word[CTRL_STOP2] = two_stop;
  endfunction
endpackage

// File: rtl/uart_tx_sequencer_fifo.sv
// uart_byte_fifo: synchronous byte FIFO with occupancy count
module uart_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic push_ok, pop_ok;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push_ok) wr <= wr + AW'(1);
      if (pop_ok) rd <= rd + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  always_ff @(posedge clk)
    if (push_ok) mem[wr] <= din;
endmodule

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: configures the UART and streams buffered bytes to TX_DATA, yielding to the core
module uart_tx_sequencer
  import uart_tx_sequencer_pkg::*;
#(
  parameter int                FIFO_DEPTH   = 8,
  parameter logic [DATA_W-1:0] BAUD_DEFAULT = 32'd115200,
  parameter int                POLL_LIMIT   = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_start,
  input  logic [DATA_W-1:0]             cfg_baud,
  input  logic                          cfg_two_stop,
  input  logic                          s_valid,
  input  logic [7:0]                    s_data,
  output logic                          s_ready,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [DATA_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  output logic [DATA_W-1:0]             cpu_rdata,
  output logic                          cpu_gnt,
  output logic                          uart_sel,
  output logic                          uart_we,
  output logic                          uart_re,
  output logic [DATA_W-1:0]             address,
  output logic [DATA_W-1:0]             data_in,
  input  logic [DATA_W-1:0]             read_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          cfg_done,
  output logic                          tx_stall
);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  seq_state_e state;
  logic [DATA_W-1:0] baud;
  logic two_stop, cfg_pend, full, empty, pop, busy;
  logic [PW-1:0] poll_cnt;
  logic [7:0] head;
  assign busy = read_out[TX_FULL_BIT];
  assign pop = state == WRITE && !cpu_req;
  assign s_ready = !full;
  assign cpu_gnt = cpu_req;
  assign cpu_rdata = read_out;
  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(s_valid && !full), .pop(pop), .din(s_data),
    .dout(head), .full(full), .empty(empty), .count(fifo_count)
  );
  // Core access wins: the FSM freezes for the cycle so its own access is simply retried.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= WAIT;
      baud <= BAUD_DEFAULT;
      two_stop <= 1'b0;
      cfg_pend <= 1'b1;
      cfg_done <= 1'b0;
      tx_stall <= 1'b0;
      poll_cnt <= '0;
    end else begin
      if (!cpu_req)
        case (state)
          WAIT: begin
            state <= CFG_BAUD;
            cfg_pend <= 1'b0;
          end
          CFG_BAUD: state <= CFG_CTRL;
          CFG_CTRL: begin
            state <= IDLE;
            cfg_done <= 1'b1;
          end
          IDLE:
            if (cfg_pend) begin
              state <= CFG_BAUD;
              cfg_pend <= 1'b0;
              cfg_done <= 1'b0;
            end else if (!empty) begin
              state <= POLL;
              poll_cnt <= '0;
            end
          POLL:
            if (!busy) state <= WRITE;
            else if (poll_cnt != PW'(POLL_LIMIT)) begin
              poll_cnt <= poll_cnt + PW'(1);
              if (poll_cnt == PW'(POLL_LIMIT - 1)) tx_stall <= 1'b1;
            end
          WRITE: state <= IDLE;
          default: state <= WAIT;
        endcase
      if (cfg_start) begin
        baud <= cfg_baud;
        two_stop <= cfg_two_stop;
        cfg_pend <= 1'b1;
        tx_stall <= 1'b0;
        poll_cnt <= '0;
      end
    end
  assign uart_sel = cpu_req || !(state inside {WAIT, IDLE});
  assign uart_we = cpu_req ? cpu_we : state inside {CFG_BAUD, CFG_CTRL, WRITE};
  assign uart_re = cpu_req ? !cpu_we : state == POLL;
  assign address = cpu_req ? cpu_addr :
                   state == CFG_BAUD ? UART_BAUD_REG :
                   state == CFG_CTRL ? UART_CTRL_REG :
                   state inside {POLL, WRITE} ? UART_TX_DATA_REG : '0;
  assign data_in = cpu_req ? cpu_wdata :
                   state == CFG_BAUD ? baud :
                   state == CFG_CTRL ? ctrl_word(two_stop) :
                   state == WRITE ? {24'b0, head} : '0;
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: directed self-checking bench for the UART TX sequencer
module tb_uart_tx_sequencer;
  import uart_tx_sequencer_pkg::*;
  logic clk = 0, reset = 0;
  logic cfg_start = 0, cfg_two_stop = 0, s_valid = 0, cpu_req = 0, cpu_we = 0;
  logic [31:0] cfg_baud = 0, cpu_addr = 0, cpu_wdata = 0, read_out = 0;
  logic [7:0] s_data = 0;
  logic s_ready, cpu_gnt, uart_sel, uart_we, uart_re, cfg_done, tx_stall;
  logic [31:0] cpu_rdata, address, data_in;
  logic [3:0] fifo_count;
  int n_tests = 0, n_fail = 0;
  localparam logic [31:0] BUSY = 32'h8000_0000;

  uart_tx_sequencer #(.FIFO_DEPTH(8), .BAUD_DEFAULT(32'd115200), .POLL_LIMIT(16)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_baud(cfg_baud), .cfg_two_stop(cfg_two_stop),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_gnt(cpu_gnt),
    .uart_sel(uart_sel), .uart_we(uart_we), .uart_re(uart_re), .address(address), .data_in(data_in),
    .read_out(read_out), .fifo_count(fifo_count), .cfg_done(cfg_done), .tx_stall(tx_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    s_valid = 1;
    s_data = b;
    tick();
    s_valid = 0;
  endtask

  initial begin
    int polls, nw;
    tick();
    tick();
    chk("rst_sel", {31'b0, uart_sel}, 0);
    chk("rst_addr", address, 0);
    chk("rst_ready", {31'b0, s_ready}, 1);
    chk("rst_cfg_done", {31'b0, cfg_done}, 0);
    chk("rst_stall", {31'b0, tx_stall}, 0);
    chk("rst_count", {28'b0, fifo_count}, 0);
    reset = 1;
    chk("wait_sel", {31'b0, uart_sel}, 0);
    tick();
    chk("baud_we", {31'b0, uart_we}, 1);
    chk("baud_addr", address, UART_BAUD_REG);
    chk("baud_data", data_in, 32'd115200);
    tick();
    chk("ctrl_we", {31'b0, uart_we}, 1);
    chk("ctrl_addr", address, UART_CTRL_REG);
    chk("ctrl_data", data_in, 32'h1);
    chk("ctrl_cfg_done", {31'b0, cfg_done}, 0);
    tick();
    chk("idle_cfg_done", {31'b0, cfg_done}, 1);
    chk("idle_sel", {31'b0, uart_sel}, 0);

    push(8'hA5);
    chk("t2_count1", {28'b0, fifo_count}, 1);
    tick();
    chk("t2_poll_re", {31'b0, uart_re}, 1);
    chk("t2_poll_addr", address, UART_TX_DATA_REG);
    tick();
    chk("t2_write_we", {31'b0, uart_we}, 1);
    chk("t2_write_data", data_in, 32'h0000_00A5);
    tick();
    chk("t2_count0", {28'b0, fifo_count}, 0);
    chk("t2_idle_sel", {31'b0, uart_sel}, 0);

    read_out = BUSY;
    push(8'h3C);
    tick();
    polls = 0;
    for (int i = 0; i < 20 && !uart_we; i++) begin
      if (uart_re) begin
        polls++;
        read_out = polls >= 6 ? 32'h0 : BUSY;
      end
      tick();
    end
    chk("t3_polls", polls, 6);
    chk("t3_write_data", data_in, 32'h3C);
    chk("t3_write_we", {31'b0, uart_we}, 1);
    tick();

    read_out = BUSY;
    for (int k = 0; k < 9; k++) begin
      s_valid = 1;
      s_data = 8'h10 + 8'(k);
      chk($sformatf("t4_ready%0d", k), {31'b0, s_ready}, k < 8 ? 1 : 0);
      tick();
    end
    s_valid = 0;
    chk("t4_count8", {28'b0, fifo_count}, 8);
    chk("t4_ready_full", {31'b0, s_ready}, 0);
    chk("t4_polling", {31'b0, uart_re}, 1);
    read_out = 0;
    nw = 0;
    for (int i = 0; i < 60 && nw < 8; i++) begin
      if (uart_we) begin
        chk($sformatf("t4_byte%0d", nw), data_in, 32'h10 + nw);
        nw++;
      end
      tick();
    end
    chk("t4_nwrites", nw, 8);
    chk("t4_count0", {28'b0, fifo_count}, 0);
    tick();
    chk("t4_no_extra", {31'b0, uart_sel}, 0);

    read_out = BUSY;
    push(8'h77);
    tick();
    chk("t5_poll", {31'b0, uart_re}, 1);
    cpu_req = 1;
    cpu_we = 1;
    cpu_addr = UART_CTRL_REG;
    cpu_wdata = 32'h3;
    #1;
    chk("t5_gnt", {31'b0, cpu_gnt}, 1);
    chk("t5_we", {31'b0, uart_we}, 1);
    chk("t5_re", {31'b0, uart_re}, 0);
    chk("t5_addr", address, UART_CTRL_REG);
    chk("t5_data", data_in, 32'h3);
    chk("t5_rdata", cpu_rdata, BUSY);
    tick();
    cpu_req = 0;
    cpu_we = 0;
    #1;
    chk("t5_still_poll", {31'b0, uart_re}, 1);
    chk("t5_poll_addr", address, UART_TX_DATA_REG);
    read_out = 0;
    tick();
    chk("t5_write_data", data_in, 32'h77);
    tick();

    read_out = BUSY;
    push(8'h5A);
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("t6_stall15", {31'b0, tx_stall}, 0);
    tick();
    chk("t6_stall16", {31'b0, tx_stall}, 1);
    tick();
    chk("t6_stall_sticky", {31'b0, tx_stall}, 1);
    cfg_start = 1;
    cfg_baud = 32'd9600;
    cfg_two_stop = 1;
    tick();
    cfg_start = 0;
    chk("t6_stall_clr", {31'b0, tx_stall}, 0);
    chk("t6_still_poll", {31'b0, uart_re}, 1);
    read_out = 0;
    tick();
    chk("t6_write_data", data_in, 32'h5A);
    tick();
    chk("t6_idle_sel", {31'b0, uart_sel}, 0);
    tick();
    chk("t6_baud_addr", address, UART_BAUD_REG);
    chk("t6_baud_data", data_in, 32'd9600);
    chk("t6_cfg_done0", {31'b0, cfg_done}, 0);
    tick();
    chk("t6_ctrl_addr", address, UART_CTRL_REG);
    chk("t6_ctrl_data", data_in, 32'h3);
    tick();
    chk("t6_cfg_done1", {31'b0, cfg_done}, 1);

    read_out = BUSY;
    push(8'h11);
    push(8'h22);
    reset = 0;
    #1;
    chk("mr_count", {28'b0, fifo_count}, 0);
    chk("mr_ready", {31'b0, s_ready}, 1);
    chk("mr_cfg_done", {31'b0, cfg_done}, 0);
    chk("mr_sel", {31'b0, uart_sel}, 0);
    tick();
    reset = 1;
    tick();
    chk("mr_baud_addr", address, UART_BAUD_REG);
    chk("mr_baud_data", data_in, 32'd115200);
    tick();
    chk("mr_ctrl_data", data_in, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
